// File: rtl/hotspot_locate.sv
// hotspot_locate
//   Scans a raster-order beamforming power map and finds the peak cell. The
//   peak's grid position is converted to LCD pixel coordinates, clamped so
//   the overlay sprite stays on screen, and published only on a rising
//   edge of display VS so the overlay never tears.
//
// Ports
//   clk_pix    pixel clock
//   rst_n      asynchronous active-low reset
//   pwr_valid  power sample valid
//   pwr_ready  block accepts a sample (high in SCAN and while resyncing)
//   pwr_data   power sample (unsigned, PWR_W bits)
//   pwr_last   final sample of the map
//   disp_vs    display VS, active high, clk_pix domain
//   pix_x      hotspot centre x
//   pix_y      hotspot centre y
//   hot_valid  displayed hotspot peak reached THRESH
//   hot_pwr    peak power of the displayed hotspot
//   frame_err  one-cycle pulse when a map is discarded
//
// Build option
//   HOTSPOT_SMOOTH_EN  when defined, a valid new position is averaged with
//                      the previous valid position (round half up).
module hotspot_locate #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 9,
  parameter int PWR_W  = 32,
  parameter int STEP_X = 30,
  parameter int STEP_Y = 30,
  parameter int OFF_X  = 15,
  parameter int OFF_Y  = 15,
  parameter int H_RES  = 480,
  parameter int V_RES  = 272,
  parameter int SPRITE = 49,
  parameter int THRESH = 1024
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             pwr_valid,
  output logic             pwr_ready,
  input  logic [PWR_W-1:0] pwr_data,
  input  logic             pwr_last,
  input  logic             disp_vs,
  output logic [15:0]      pix_x,
  output logic [15:0]      pix_y,
  output logic             hot_valid,
  output logic [PWR_W-1:0] hot_pwr,
  output logic             frame_err
);

  localparam int TOTAL = GRID_W * GRID_H;
  localparam int HALF  = (SPRITE - 1) / 2;
  localparam int CW    = $clog2(GRID_W);
  localparam int RW    = $clog2(GRID_H + 1);
  localparam int NW    = $clog2(TOTAL + 1);

  localparam logic [NW-1:0]    LAST_N   = NW'(TOTAL - 1);
  localparam logic [NW-1:0]    FULL_N   = NW'(TOTAL);
  localparam logic [CW-1:0]    COL_LAST = CW'(GRID_W - 1);
  localparam logic [PWR_W-1:0] THR      = PWR_W'(THRESH);

  typedef enum logic [2:0] {SCAN, DROP, MAP, PEND, COMMIT} state_t;

  state_t            state, state_nx;
  logic [NW-1:0]     cnt;
  logic [CW-1:0]     col, best_col;
  logic [RW-1:0]     row, best_row;
  logic [PWR_W-1:0]  max;
  logic [15:0]       x_new, y_new;
  logic              valid_new;
  logic              vs_d;
  logic              xfer;
  logic              vs_rise;
  logic              bad_map;

  // Grid index to clamped pixel centre.
  function automatic logic [15:0] place(input logic [15:0] idx, input int step,
                                        input int off, input int lo, input int hi);
    logic [15:0] p;
    p = 16'(off) + idx * 16'(step);
    if (p < 16'(lo)) p = 16'(lo);
    if (p > 16'(hi)) p = 16'(hi);
    return p;
  endfunction

  // Average with round half up; 17-bit sum avoids overflow.
  function automatic logic [15:0] avg(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b} + 17'd1;
    return s[16:1];
  endfunction

  assign xfer    = pwr_valid && pwr_ready;
  assign vs_rise = disp_vs && !vs_d;
  // Early pwr_last, or a sample beyond the full map, discards the map.
  assign bad_map = (pwr_last && cnt != LAST_N) || (cnt == FULL_N);

  always_comb begin
    state_nx  = state;
    pwr_ready = 1'b0;
    case (state)
      SCAN: begin
        pwr_ready = 1'b1;
        if (xfer) begin
          if (cnt == FULL_N && !pwr_last)        state_nx = DROP;
          else if (pwr_last && cnt == LAST_N)    state_nx = MAP;
        end
      end
      DROP: begin
        pwr_ready = 1'b1;
        if (xfer && pwr_last) state_nx = SCAN;
      end
      MAP:     state_nx = PEND;
      PEND:    if (vs_rise) state_nx = COMMIT;
      COMMIT:  state_nx = SCAN;
      default: state_nx = SCAN;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      vs_d      <= 1'b0;
      cnt       <= '0;
      col       <= '0;
      row       <= '0;
      best_col  <= '0;
      best_row  <= '0;
      max       <= '0;
      x_new     <= '0;
      y_new     <= '0;
      valid_new <= 1'b0;
      pix_x     <= 16'(H_RES / 2);
      pix_y     <= 16'(V_RES / 2);
      hot_valid <= 1'b0;
      hot_pwr   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      vs_d      <= disp_vs;
      frame_err <= 1'b0;
      case (state)
        SCAN: begin
          if (xfer) begin
            if (bad_map) begin
              frame_err <= 1'b1;
              cnt       <= '0;
              col       <= '0;
              row       <= '0;
              max       <= '0;
            end else begin
              // First sample always loads; later ones only on strictly greater.
              if (cnt == '0 || pwr_data > max) begin
                max      <= pwr_data;
                best_col <= col;
                best_row <= row;
              end
              cnt <= cnt + 1'b1;
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        MAP: begin
          x_new     <= place(16'(best_col), STEP_X, OFF_X, HALF, H_RES - 1 - HALF);
          y_new     <= place(16'(best_row), STEP_Y, OFF_Y, HALF, V_RES - 1 - HALF);
          valid_new <= (max >= THR);
        end
        COMMIT: begin
`ifdef HOTSPOT_SMOOTH_EN
          if (hot_valid && valid_new) begin
            pix_x <= avg(pix_x, x_new);
            pix_y <= avg(pix_y, y_new);
          end else begin
            pix_x <= x_new;
            pix_y <= y_new;
          end
`else
          pix_x <= x_new;
          pix_y <= y_new;
`endif
          hot_pwr   <= max;
          hot_valid <= valid_new;
          cnt       <= '0;
          col       <= '0;
          row       <= '0;
          max       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hotspot_locate.sv
module tb_hotspot_locate;

  localparam int TOTAL = 144;

  logic        clk_pix = 1'b0;
  logic        rst_n;
  logic        pwr_valid;
  logic        pwr_ready;
  logic [31:0] pwr_data;
  logic        pwr_last;
  logic        disp_vs;
  logic [15:0] pix_x;
  logic [15:0] pix_y;
  logic        hot_valid;
  logic [31:0] hot_pwr;
  logic        frame_err;

  hotspot_locate dut (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .pwr_valid(pwr_valid),
    .pwr_ready(pwr_ready),
    .pwr_data (pwr_data),
    .pwr_last (pwr_last),
    .disp_vs  (disp_vs),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .hot_valid(hot_valid),
    .hot_pwr  (hot_pwr),
    .frame_err(frame_err)
  );

  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int errors = 0;

  // Expected outputs (model state)
  int exp_x = 240, exp_y = 136, exp_valid = 0, exp_ferr = 0, exp_ready = 1;
  longint exp_pwr = 0;
  // Pending result of a completed map, waiting for VS
  int pend = 0, pend_x, pend_y, pend_valid;
  longint pend_pwr;
  bit check_en = 1'b0;

  logic [31:0] map_data [0:255];

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk_pix) begin
    if (check_en) begin
      chk("pix_x", pix_x, exp_x);
      chk("pix_y", pix_y, exp_y);
      chk("hot_valid", hot_valid, exp_valid);
      chk("hot_pwr", hot_pwr, exp_pwr);
      chk("frame_err", frame_err, exp_ferr);
      chk("pwr_ready", pwr_ready, exp_ready);
    end
  end

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference: first strict maximum in raster order, mapped to pixels.
  task automatic model_map();
    int bi = 0;
    longint best = map_data[0];
    for (int k = 1; k < TOTAL; k++)
      if (map_data[k] > best) begin best = map_data[k]; bi = k; end
    pend_x     = clampi(15 + 30 * (bi % 16), 24, 480 - 1 - 24);
    pend_y     = clampi(15 + 30 * (bi / 16), 24, 272 - 1 - 24);
    pend_valid = (best >= 1024) ? 1 : 0;
    pend_pwr   = best;
    pend       = 1;
  endtask

  task automatic fill(input logic [31:0] v);
    for (int k = 0; k < 256; k++) map_data[k] = v;
  endtask

  task automatic tick();
    @(posedge clk_pix); #1;
  endtask

  // Streams n samples with random idle gaps; pwr_last on index last_idx.
  // disp_vs is pulsed around sample vs_mid when vs_mid >= 0.
  task automatic send_map(input int n, input int last_idx, input int vs_mid);
    int err_idx = -1;
    int i = 0;
    if (last_idx < TOTAL - 1) err_idx = last_idx;
    else if (last_idx > TOTAL - 1) err_idx = TOTAL;
    while (i < n) begin
      if ($urandom_range(0, 3) == 0) begin
        pwr_valid = 1'b0; pwr_data = $urandom; pwr_last = 1'b0;
      end else begin
        pwr_valid = 1'b1; pwr_data = map_data[i]; pwr_last = (i == last_idx);
      end
      disp_vs = (vs_mid >= 0 && i >= vs_mid && i < vs_mid + 2);
      tick();
      exp_ferr = (pwr_valid && i == err_idx) ? 1 : 0;
      if (pwr_valid) i++;
    end
    pwr_valid = 1'b0; pwr_last = 1'b0; disp_vs = 1'b0;
    if (err_idx < 0) begin
      model_map();
      exp_ready = 0;
    end
    tick();
    exp_ferr = 0;
    tick();
  endtask

  task automatic do_vs();
    disp_vs = 1'b1;
    tick();
    tick();
    if (pend != 0) begin
`ifdef HOTSPOT_SMOOTH_EN
      if (exp_valid != 0 && pend_valid != 0) begin
        exp_x = (exp_x + pend_x + 1) / 2;
        exp_y = (exp_y + pend_y + 1) / 2;
      end else begin
        exp_x = pend_x; exp_y = pend_y;
      end
`else
      exp_x = pend_x; exp_y = pend_y;
`endif
      exp_valid = pend_valid;
      exp_pwr   = pend_pwr;
      exp_ready = 1;
      pend      = 0;
    end
    disp_vs = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pwr_valid = 1'b0; pwr_data = '0; pwr_last = 1'b0; disp_vs = 1'b0;
    check_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Below threshold: all 500
    fill(32'd500);
    send_map(TOTAL, TOTAL - 1, -1);
    do_vs();
    chk("lit_thr_valid", hot_valid, 0);
    chk("lit_thr_x", pix_x, 24);
    chk("lit_thr_pwr", hot_pwr, 500);

    // Single peak at (5,3); VS edge during scan must be ignored
    fill(32'd100);
    map_data[53] = 32'd5000;
    send_map(TOTAL, TOTAL - 1, 50);
    repeat (6) tick();
    do_vs();
    chk("lit_sp_x", pix_x, 165);
    chk("lit_sp_y", pix_y, 105);
    chk("lit_sp_valid", hot_valid, 1);
    chk("lit_sp_pwr", hot_pwr, 5000);

    // Peak at (7,3) -> x 225 (averaged with 165 when smoothing)
    fill(32'd100);
    map_data[55] = 32'd3000;
    send_map(TOTAL, TOTAL - 1, -1);
    do_vs();
`ifdef HOTSPOT_SMOOTH_EN
    chk("lit_p2_x", pix_x, 195);
`else
    chk("lit_p2_x", pix_x, 225);
`endif
    chk("lit_p2_y", pix_y, 105);

    // Short map, then a full tie map
    fill(32'd100);
    send_map(101, 100, -1);
    do_vs();
    map_data[0]   = 32'd7000;
    map_data[143] = 32'd7000;
    send_map(TOTAL, TOTAL - 1, -1);
    do_vs();
`ifdef HOTSPOT_SMOOTH_EN
    chk("lit_tie_x", pix_x, 125);
    chk("lit_tie_y", pix_y, 65);
`else
    chk("lit_tie_x", pix_x, 24);
    chk("lit_tie_y", pix_y, 24);
`endif
    chk("lit_tie_pwr", hot_pwr, 7000);

    // Overrun: 150 samples, pwr_last on the final one
    fill(32'd9000);
    send_map(150, 149, -1);
    do_vs();

    // Asynchronous reset in the middle of a scan
    fill(32'd100);
    for (int k = 0; k < 60; k++) begin
      pwr_valid = 1'b1; pwr_data = map_data[k]; pwr_last = 1'b0;
      tick();
    end
    pwr_valid = 1'b0;
    rst_n = 1'b0;
    exp_x = 240; exp_y = 136; exp_valid = 0; exp_pwr = 0; exp_ready = 1; pend = 0;
    #1;
    chk("lit_rst_x", pix_x, 240);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Clamp high: peak at (15,8)
    fill(32'd100);
    map_data[143] = 32'd6000;
    send_map(TOTAL, TOTAL - 1, -1);
    do_vs();
    chk("lit_hi_x", pix_x, 455);
    chk("lit_hi_y", pix_y, 247);

    // Randomized maps
    for (int m = 0; m < 8; m++) begin
      int top;
      top = (m % 3 == 0) ? 1023 : 4000;
      for (int k = 0; k < 256; k++) map_data[k] = $urandom_range(0, top);
      if ($urandom_range(0, 1) == 1) map_data[$urandom_range(0, 143)] = map_data[$urandom_range(0, 143)];
      if ($urandom_range(0, 2) == 0) do_vs();
      send_map(TOTAL, TOTAL - 1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 140)) : -1);
      repeat ($urandom_range(0, 4)) tick();
      do_vs();
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hotspot_locate.md
Name: hotspot_locate

Overview:
- Consumes the per-frame beamforming power map (raster order, row 0 col 0 first) produced by the acoustic processing chain.
- Finds the peak cell and maps its grid position to LCD pixel coordinates.
- Presents the coordinates as stable pix_x/pix_y to the hotspot overlay renderer.
- Updates its outputs only at a display vertical-sync edge, so the overlay never tears mid-frame.

Parameters:
- GRID_W, 16, power-map columns
- GRID_H, 9, power-map rows
- PWR_W, 32, power sample width (unsigned)
- STEP_X, 30, pixels per grid column
- STEP_Y, 30, pixels per grid row
- OFF_X, 15, pixel x of column 0 centre
- OFF_Y, 15, pixel y of row 0 centre
- H_RES, 480, display width
- V_RES, 272, display height
- SPRITE, 49, overlay sprite size (odd); HALF=(SPRITE-1)/2
- THRESH, 1024, minimum peak power for a valid hotspot

Ports:
- clk_pix  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- pwr_valid  in  1  power sample valid
- pwr_ready  out  1  block accepts a sample
- pwr_data  in  PWR_W  power sample
- pwr_last  in  1  marks the final sample of the map
- disp_vs  in  1  display VS (active high, clk_pix domain)
- pix_x  out  16  hotspot centre x
- pix_y  out  16  hotspot centre y
- hot_valid  out  1  displayed hotspot is valid
- hot_pwr  out  PWR_W  peak power of the displayed hotspot
- frame_err  out  1  one-cycle pulse when a map is discarded

Behaviour:
- Reset values:
  - pix_x=H_RES/2, pix_y=V_RES/2
  - hot_valid=0, hot_pwr=0, frame_err=0, pwr_ready=1
  - state=SCAN, counters=0, max=0
- Transfer occurs on a cycle where pwr_valid&&pwr_ready.
- SCAN state:
  - pwr_ready=1.
  - col/row counters advance per transfer.
  - Candidate updates only if pwr_data > max (strict), so on ties the first occurrence in raster order wins.
  - The first sample of each map always loads as the candidate.
- pwr_last on transfer number n (0-based):
  - If n==GRID_W*GRID_H-1, go to MAP.
  - Otherwise pulse frame_err, clear counters and max, and stay in SCAN.
- Overrun: a transfer at n==GRID_W*GRID_H without pwr_last is treated the same as a mismatch. frame_err pulses, the sample is dropped, and the block resynchronises on the next pwr_last, discarding everything up to and including it.
- MAP state (1 cycle, pwr_ready=0):
  - x = OFF_X + col*STEP_X and y = OFF_Y + row*STEP_Y, 16-bit unsigned.
  - Clamp x to [HALF, H_RES-1-HALF] and y to [HALF, V_RES-1-HALF].
  - valid_n = (max >= THRESH).
  - Go to PEND.
- PEND state (pwr_ready=0): wait for a rising edge of disp_vs, detected with a one-register delay.
- COMMIT state (1 cycle):
  - Load pix_x, pix_y, hot_pwr and hot_valid=valid_n.
  - Clear max/counters and return to SCAN.
  - Outputs change exactly 2 clk_pix cycles after the first cycle disp_vs is seen high.
- Outputs hold between commits. If valid_n=0, hot_valid goes 0 but pix_x/pix_y/hot_pwr still load the new values.
- VS edges during SCAN/MAP are ignored. There is no queueing: a map completing after an edge waits for the next edge.
- An asynchronous reset mid-scan returns to the reset values immediately. The partial map is lost and frame_err is not pulsed.
- pwr_data is sampled only on transfer cycles; it may be X otherwise.

Optional Feature:
- Macro: HOTSPOT_SMOOTH_EN.
- Defined:
  - At COMMIT, when both the old hot_valid and valid_n are 1: pix_x=(pix_x+x_new+1)>>1, same for y. This rounds half up, uses a 17-bit intermediate, and the result stays within the clamp range.
  - If either flag is 0, load x_new/y_new directly.
- Undefined: always load directly.

Test Plan:
- Single peak:
  - Stimulus: 144-sample map with all samples 100 except the sample at (col5,row3)=5000; pulse disp_vs.
  - Response: pix_x=165, pix_y=105, hot_valid=1, hot_pwr=5000, 2 cycles after VS high.
- Tie and clamp:
  - Stimulus: 7000 at (0,0) and at (15,8).
  - Response: first occurrence wins; pix_x=24 and pix_y=24 (15 clamped to HALF=24).
- Clamp high:
  - Stimulus: peak at (15,8).
  - Response: x=465→455, y=255→247.
- Below threshold:
  - Stimulus: all samples 500.
  - Response: hot_valid=0 after commit, pix_x=15→24, hot_pwr=500.
- Short map:
  - Stimulus: pwr_last on sample 100.
  - Response: frame_err pulses 1 cycle, outputs unchanged; the next full map commits normally.
- Backpressure / VS timing:
  - Stimulus: VS edge during SCAN, then the map completes.
  - Response: no update until the next VS edge; pwr_ready=0 throughout PEND. With HOTSPOT_SMOOTH_EN, a previous value of 165 and a new value of 225 gives 195.
